// File: rtl/mem_bank_responder_if.sv
// Request/response bus between requesters, a memory bank responder and the response sink.
interface mem_bank_responder_if;
    logic [3:0]   bank_id;
    logic         req_valid;
    logic [127:0] req_data;
    logic [14:0]  req_pAddress;
    logic [3:0]   req_return;
    logic [15:0]  req_size;
    logic         req_rw;
    logic [3:0]   req_dest;
    logic         req_full;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic [14:0]  resp_pAddress;
    logic [3:0]   resp_dest;
    logic [3:0]   resp_return;
    logic [15:0]  resp_size;
    logic         resp_rw;
    logic         resp_full;
    logic         busy;

    modport master (
        output bank_id, req_valid, req_data, req_pAddress, req_return, req_size, req_rw,
               req_dest, resp_full,
        input  req_full, resp_valid, resp_data, resp_pAddress, resp_dest, resp_return,
               resp_size, resp_rw, busy
    );

    modport slave (
        input  bank_id, req_valid, req_data, req_pAddress, req_return, req_size, req_rw,
               req_dest, resp_full,
        output req_full, resp_valid, resp_data, resp_pAddress, resp_dest, resp_return,
               resp_size, resp_rw, busy
    );
endinterface

// File: rtl/mem_bank_responder.sv
// Memory bank responder: in-order request queue, posted line writes, fixed-latency line reads.
module mem_bank_responder #(
    parameter int unsigned LINES = 64,
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    mem_bank_responder_if.slave bus
);
    localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic [127:0] data;
        logic [14:0]  paddr;
        logic [3:0]   ret;
        logic [15:0]  size;
        logic         rw;
    } entry_t;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic             full_q, busy_q, resp_valid_q;
    logic [127:0]     resp_data_q;
    logic [14:0]      resp_paddr_q;
    logic [3:0]       resp_dest_q;
    logic [15:0]      resp_size_q;
    entry_t           fifo_q [DEPTH];
    logic [127:0]     mem_q [LINES];
    entry_t           head, req_entry;
    logic             accept, pop, mem_we, latch_req, capture;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_entry = '{data: bus.req_data, paddr: bus.req_pAddress, ret: bus.req_return,
                         size: bus.req_size, rw: bus.req_rw};
    assign head   = fifo_q[rd_q];
    // Full blocks enqueue even when the head pops on the same edge.
    assign accept = bus.req_valid && (bus.req_dest == bus.bank_id) && !full_q;

    // Queue pointer/count next-state; pop comes from the FSM
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        if (accept) wr_d = ptr_inc(wr_q);
        if (pop)    rd_d = ptr_inc(rd_q);
    end

    // Queue storage, no reset needed since count gates every use
    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_q] <= req_entry;
    end

    // Queue pointers, count and the registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            busy_q  <= (count_d != '0) || (state_d != IDLE);
        end
    end

    // FSM state and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: pop in IDLE, count down in ACCESS, hold response in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        mem_we    = 1'b0;
        latch_req = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head.rw) begin
                        mem_we = 1'b1;
                    end else begin
                        latch_req = 1'b1;
                        cnt_d     = LAT_W'(LAT - 1);
                        state_d   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (!bus.resp_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line memory; posted writes land at the pop edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LINES; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[head.paddr[4 +: IDX_W]] <= head.data;
        end
    end

    // Response registers: header latched at pop, data captured at end of access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_paddr_q <= '0;
            resp_dest_q  <= '0;
            resp_size_q  <= '0;
        end else begin
            resp_valid_q <= (state_d == RESP);
            if (latch_req) begin
                resp_paddr_q <= head.paddr;
                resp_dest_q  <= head.ret;
                resp_size_q  <= head.size;
            end
            if (capture) resp_data_q <= mem_q[resp_paddr_q[4 +: IDX_W]];
        end
    end

    assign bus.req_full      = full_q;
    assign bus.busy          = busy_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_pAddress = resp_paddr_q;
    assign bus.resp_dest     = resp_dest_q;
    assign bus.resp_return   = bus.bank_id;
    assign bus.resp_size     = resp_size_q;
    assign bus.resp_rw       = 1'b0;
endmodule

// File: tb/tb_mem_bank_responder.sv
// Self-checking bench for mem_bank_responder: vector table, corner sequences, random traffic.
module tb_mem_bank_responder;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  BANK  = 4'hA;
    localparam int          NV    = 11;
    localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    typedef struct {
        logic         rw;
        logic [3:0]   dest;
        logic [14:0]  addr;
        logic [127:0] data;
        logic [3:0]   ret;
        logic [15:0]  size;
        logic         exp_resp;
        logic [127:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [127:0] data;
        logic [14:0]  addr;
        logic [3:0]   ret;
        logic [15:0]  size;
    } exp_t;

    logic clk;
    logic rst;
    mem_bank_responder_if bus ();

    mem_bank_responder #(.LINES(64), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           n_checks = 0;
    int           n_pass   = 0;
    vec_t         vecs [NV];
    logic [127:0] model_mem [64];
    exp_t         exp_q [$];
    bit           mon_en    = 1'b0;
    bit           send_done = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [167:0] resp_vec();
        return {bus.resp_data, bus.resp_pAddress, bus.resp_dest, bus.resp_return,
                bus.resp_size, bus.resp_rw};
    endfunction

    function automatic logic [127:0] line_data(input int i);
        return {96'hC0DE, 32'(i)};
    endfunction

    task automatic set_req(input logic rw, input logic [3:0] dest, input logic [14:0] addr,
                           input logic [127:0] data, input logic [3:0] ret, input logic [15:0] size);
        bus.req_rw       = rw;
        bus.req_dest     = dest;
        bus.req_pAddress = addr;
        bus.req_data     = data;
        bus.req_return   = ret;
        bus.req_size     = size;
        bus.req_valid    = 1'b1;
    endtask

    // Hold the driven request until an edge sees req_full low (bounded).
    task automatic send_held(output bit ok);
        int n;
        bit was_full;
        n  = 0;
        ok = 1'b0;
        do begin
            was_full = bus.req_full;
            @(posedge clk); #1;
            n++;
            if (!was_full) ok = 1'b1;
        end while (!ok && n < 300);
        bus.req_valid = 1'b0;
    endtask

    // One request from idle; report busy after the accept edge and first resp_valid latency.
    task automatic apply(input logic rw, input logic [3:0] dest, input logic [14:0] addr,
                         input logic [127:0] data, input logic [3:0] ret, input logic [15:0] size,
                         output logic busy0, output int lat, output logic [167:0] v);
        set_req(rw, dest, addr, data, ret, size);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        busy0 = bus.busy;
        lat   = 0;
        v     = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                lat = k;
                v   = resp_vec();
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle", 256'(bus.busy), 256'(0));
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_flags"}, 256'({bus.req_full, bus.resp_valid, bus.busy}), 256'(0));
        chk({pfx, "_fields"}, 256'(resp_vec()), 256'({128'h0, 15'h0, 4'h0, BANK, 16'h0, 1'b0}));
    endtask

    task automatic bus_idle();
        bus.req_valid    = 1'b0;
        bus.req_data     = '0;
        bus.req_pAddress = '0;
        bus.req_return   = '0;
        bus.req_size     = '0;
        bus.req_rw       = 1'b0;
        bus.req_dest     = '0;
        bus.resp_full    = 1'b0;
    endtask

    // Response monitor for the random phase: order, content and stall stability.
    initial begin
        bit           stall_prev;
        logic [167:0] stall_vec;
        exp_t         e;
        stall_prev = 1'b0;
        stall_vec  = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_prev)
                    chk("resp_hold", 256'({bus.resp_valid, resp_vec()}), 256'({1'b1, stall_vec}));
                if (bus.resp_valid && !bus.resp_full) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 256'(bus.resp_valid), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_fields", 256'(resp_vec()),
                            256'({e.data, e.addr, e.ret, BANK, e.size, 1'b0}));
                    end
                end
                stall_prev = bus.resp_valid && bus.resp_full;
                stall_vec  = resp_vec();
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        logic         busy0;
        int           lat;
        logic [167:0] v;
        logic [167:0] held;
        logic [131:0] got [$];
        bit           ok;
        bit           pend;
        bit           will_accept;
        int           nv;

        bus_idle();
        bus.bank_id = BANK;
        rst = 1'b0;
        #2;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // rw, dest, addr, data, ret, size, exp_resp, exp_data
        vecs[0]  = '{1'b1, 4'hA, 15'h0030, 128'h1234, 4'h0, 16'h0000, 1'b0, 128'h0};
        vecs[1]  = '{1'b0, 4'hA, 15'h0030, 128'h0,    4'h3, 16'h0010, 1'b1, 128'h1234};
        vecs[2]  = '{1'b0, 4'hB, 15'h0030, 128'h0,    4'h3, 16'h0010, 1'b0, 128'h0};
        vecs[3]  = '{1'b1, 4'hA, 15'h03F0, D1,        4'h0, 16'h0000, 1'b0, 128'h0};
        vecs[4]  = '{1'b0, 4'hA, 15'h03F0, 128'h0,    4'h5, 16'hBEEF, 1'b1, D1};
        vecs[5]  = '{1'b0, 4'hA, 15'h7C30, 128'h0,    4'hF, 16'hFFFF, 1'b1, 128'h1234};
        vecs[6]  = '{1'b0, 4'hA, 15'h0040, 128'h0,    4'h1, 16'h0002, 1'b1, 128'h0};
        vecs[7]  = '{1'b1, 4'hB, 15'h0040, {128{1'b1}}, 4'h0, 16'h0000, 1'b0, 128'h0};
        vecs[8]  = '{1'b0, 4'hA, 15'h0040, 128'h0,    4'h2, 16'h0003, 1'b1, 128'h0};
        vecs[9]  = '{1'b1, 4'hA, 15'h0035, 128'h5555, 4'h0, 16'h0000, 1'b0, 128'h0};
        vecs[10] = '{1'b0, 4'hA, 15'h0030, 128'h0,    4'h4, 16'h0001, 1'b1, 128'h5555};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rw, vecs[i].dest, vecs[i].addr, vecs[i].data, vecs[i].ret,
                  vecs[i].size, busy0, lat, v);
            chk($sformatf("vec%0d_busy", i), 256'(busy0), 256'(vecs[i].dest == BANK));
            if (vecs[i].exp_resp) begin
                chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(LAT + 1));
                chk($sformatf("vec%0d_resp", i), 256'(v),
                    256'({vecs[i].exp_data, vecs[i].addr, vecs[i].ret, BANK, vecs[i].size, 1'b0}));
            end else begin
                chk($sformatf("vec%0d_noresp", i), 256'(lat), 256'(0));
            end
            wait_idle();
        end

        // Response held under back-pressure, single transfer on release
        bus.resp_full = 1'b1;
        apply(1'b0, BANK, 15'h03F0, 128'h0, 4'h7, 16'h00AA, busy0, lat, v);
        chk("stall_latency", 256'(lat), 256'(LAT + 1));
        held = v;
        chk("stall_resp", 256'(held), 256'({D1, 15'h03F0, 4'h7, BANK, 16'h00AA, 1'b0}));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", k), 256'({bus.resp_valid, resp_vec()}), 256'({1'b1, held}));
        end
        bus.resp_full = 1'b0;
        @(posedge clk); #1;
        chk("stall_done", 256'(bus.resp_valid), 256'(0));
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) nv++;
        end
        chk("stall_single", 256'(nv), 256'(0));
        wait_idle();

        // Fill the queue behind a stalled response; sixth request waits for a pop
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, BANK, 15'((8 + i) * 16), line_data(i), 4'h0, 16'h0);
            send_held(ok);
        end
        wait_idle();
        bus.resp_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b0, BANK, 15'((8 + i) * 16), 128'h0, 4'(i), 16'(i));
            send_held(ok);
            chk($sformatf("fill_accept%0d", i), 256'(ok), 256'(1));
            if (i == 3) chk("fill_not_full", 256'(bus.req_full), 256'(0));
            if (i == 4) chk("fill_full", 256'(bus.req_full), 256'(1));
        end
        set_req(1'b0, BANK, 15'(13 * 16), 128'h0, 4'd5, 16'd5);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("fill_hold%0d", k), 256'(bus.req_full), 256'(1));
        end
        bus.resp_full = 1'b0;
        pend = 1'b1;
        got.delete();
        for (int c = 0; c < 80 && got.size() < 6; c++) begin
            will_accept = pend && !bus.req_full;
            if (bus.resp_valid && !bus.resp_full) got.push_back({bus.resp_data, bus.resp_dest});
            @(posedge clk); #1;
            if (will_accept) begin
                pend = 1'b0;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        chk("fill_sixth_accepted", 256'(pend), 256'(0));
        chk("fill_resp_count", 256'(got.size()), 256'(6));
        for (int i = 0; i < 6; i++)
            chk($sformatf("fill_order%0d", i), (i < got.size()) ? 256'(got[i]) : {256{1'bx}},
                256'({line_data(i), 4'(i)}));
        wait_idle();

        // Reset while a read is in ACCESS with two more queued
        set_req(1'b1, BANK, 15'h0140, 128'hFACE, 4'h0, 16'h0);
        send_held(ok);
        wait_idle();
        set_req(1'b0, BANK, 15'h0140, 128'h0, 4'h1, 16'h0);
        send_held(ok);
        set_req(1'b0, BANK, 15'h0080, 128'h0, 4'h2, 16'h0);
        send_held(ok);
        set_req(1'b0, BANK, 15'h0090, 128'h0, 4'h3, 16'h0);
        send_held(ok);
        chk("midrst_busy_before", 256'(bus.busy), 256'(1));
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #2 rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) nv++;
        end
        chk("midrst_no_resp", 256'(nv), 256'(0));
        chk("midrst_idle", 256'(bus.busy), 256'(0));
        apply(1'b0, BANK, 15'h0140, 128'h0, 4'h6, 16'h0, busy0, lat, v);
        chk("midrst_mem_cleared", 256'(v), 256'({128'h0, 15'h0140, 4'h6, BANK, 16'h0, 1'b0}));
        wait_idle();

        // Random traffic against a transaction-level model
        rst = 1'b0;
        #2;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        fork
            begin
                logic         rw;
                logic         match;
                logic [3:0]   dest;
                logic [14:0]  addr;
                logic [127:0] data;
                logic [3:0]   ret;
                logic [15:0]  size;
                bit           acc;
                exp_t         e;
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    rw    = 1'($urandom_range(0, 1));
                    match = ($urandom_range(0, 7) != 0);
                    dest  = match ? BANK : (BANK ^ 4'($urandom_range(1, 15)));
                    addr  = 15'($urandom);
                    addr[9:4] = 6'($urandom_range(0, 7));
                    data  = {$urandom, $urandom, $urandom, $urandom};
                    ret   = 4'($urandom);
                    size  = 16'($urandom);
                    set_req(rw, dest, addr, data, ret, size);
                    if (match) begin
                        send_held(acc);
                        chk("rand_accept", 256'(acc), 256'(1));
                        if (acc) begin
                            if (rw) begin
                                model_mem[addr[9:4]] = data;
                            end else begin
                                e = '{data: model_mem[addr[9:4]], addr: addr, ret: ret, size: size};
                                exp_q.push_back(e);
                            end
                        end
                    end else begin
                        @(posedge clk); #1;
                        bus.req_valid = 1'b0;
                    end
                end
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    @(posedge clk); #1;
                    bus.resp_full = ($urandom_range(0, 3) == 0);
                end
                bus.resp_full = 1'b0;
            end
        join
        nv = 0;
        while (exp_q.size() != 0 && nv < 2000) begin
            @(posedge clk); #1;
            nv++;
        end
        chk("rand_drain", 256'(exp_q.size()), 256'(0));
        wait_idle();
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
